// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the 30-input adder tree and its upstream frame
// loader: operand count and width, minimum frame hold time, sum width and the
// operand type. Also provides a small width helper used for counters.
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int NUM_INPUTS  = 30;
    localparam int DATA_W      = 8;
    localparam int HOLD_CYCLES = 5;
    localparam int SUM_W       = 13;

    typedef logic [DATA_W-1:0] operand_t;

    // Bits needed to count 0..n-1; never less than one so n==1 still yields
    // a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_frame_loader_if.sv
// ---------------------------------------------------------------------------
// adder_frame_loader_if
// Byte-stream input handshake and parallel frame output of the frame loader.
//   in_data/in_valid/in_sof/in_ready : byte stream into the loader
//   frame_data/frame_valid/frame_start/frame_ready : held frame to the adder
//   sync_err/frames_out : status
// Modports: slave  = the loader itself
//           master = the environment (byte source and frame consumer)
// ---------------------------------------------------------------------------
interface adder_frame_loader_if #(
    parameter int NUM_INPUTS = adder_pkg::NUM_INPUTS,
    parameter int DATA_W     = adder_pkg::DATA_W,
    parameter int CNT_W      = 16
);

    logic [DATA_W-1:0]            in_data;
    logic                         in_valid;
    logic                         in_sof;
    logic                         in_ready;
    logic [NUM_INPUTS*DATA_W-1:0] frame_data;
    logic                         frame_valid;
    logic                         frame_start;
    logic                         frame_ready;
    logic                         sync_err;
    logic [CNT_W-1:0]             frames_out;

    modport slave (
        input  in_data, in_valid, in_sof, frame_ready,
        output in_ready, frame_data, frame_valid, frame_start, sync_err, frames_out
    );

    modport master (
        output in_data, in_valid, in_sof, frame_ready,
        input  in_ready, frame_data, frame_valid, frame_start, sync_err, frames_out
    );

endinterface

// File: rtl/adder_frame_loader_hold_timer.sv
// ---------------------------------------------------------------------------
// frame_hold_timer
// Counts the cycles the current output frame has been valid, saturating at
// HOLD_CYCLES-1, and flags the cycle in which the consumer may release it.
//   clk, rst      : clock, synchronous active-high reset
//   frame_valid   : output frame is being presented
//   load          : a new frame is loaded at the coming edge (restarts count)
//   frame_ready   : consumer is done with the frame
//   frame_release : frame is released at the coming edge
// ---------------------------------------------------------------------------
module frame_hold_timer #(
    parameter int HOLD_CYCLES = adder_pkg::HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_valid,
    input  logic load,
    input  logic frame_ready,
    output logic frame_release
);

    import adder_pkg::cnt_width;

    localparam int             HC_W     = cnt_width(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_CYCLES - 1);

    logic [HC_W-1:0] hold_cnt_r;

    // Hold counter: cleared on each new frame, counts valid cycles, saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= '0;
        end else if (load) begin
            hold_cnt_r <= '0;
        end else if (frame_valid && (hold_cnt_r != HOLD_MAX)) begin
            hold_cnt_r <= hold_cnt_r + HC_W'(1);
        end
    end

    // frame_ready is only honoured once the minimum hold window has elapsed.
    always_comb begin
        frame_release = frame_valid && frame_ready && (hold_cnt_r == HOLD_MAX);
    end

endmodule

// File: rtl/adder_frame_loader.sv
// ---------------------------------------------------------------------------
// adder_frame_loader
// Deserialises a byte stream into a NUM_INPUTS-operand frame and presents it
// in parallel to the adder tree. A fill buffer collects the next frame while
// the output buffer holds the current one for at least HOLD_CYCLES cycles.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (discards partial and held frames)
//   bus : adder_frame_loader_if.slave (byte input, frame output, status)
// ---------------------------------------------------------------------------
module adder_frame_loader #(
    parameter int NUM_INPUTS  = adder_pkg::NUM_INPUTS,
    parameter int DATA_W      = adder_pkg::DATA_W,
    parameter int HOLD_CYCLES = adder_pkg::HOLD_CYCLES,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_frame_loader_if.slave   bus
);

    import adder_pkg::cnt_width;

    localparam int              IDX_W    = cnt_width(NUM_INPUTS);
    localparam int              FRAME_W  = NUM_INPUTS * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    logic [IDX_W-1:0]  wr_idx_r;
    logic [DATA_W-1:0] fill_buf_r [NUM_INPUTS];
    logic              fill_full_r;
    logic [FRAME_W-1:0] frame_data_r;
    logic              frame_valid_r;
    logic              frame_start_r;
    logic              sync_err_r;
    logic [CNT_W-1:0]  frames_out_r;

    logic               accept_s;
    logic               transfer_s;
    logic               release_s;
    logic [FRAME_W-1:0] fill_flat_s;

    // Handshake decode. accept and transfer are mutually exclusive because
    // one needs an empty fill buffer and the other a full one.
    always_comb begin
        accept_s   = bus.in_valid && !fill_full_r;
        transfer_s = fill_full_r && (!frame_valid_r || release_s);
    end

    // Flatten the fill buffer into the output layout (operand k at k*DATA_W).
    always_comb begin
        fill_flat_s = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            fill_flat_s[k*DATA_W +: DATA_W] = fill_buf_r[k];
        end
    end

    // Fill side: byte write pointer, fill buffer, full flag and resync error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_r    <= '0;
            fill_full_r <= 1'b0;
            sync_err_r  <= 1'b0;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                fill_buf_r[k] <= '0;
            end
        end else if (accept_s) begin
            if (bus.in_sof) begin
                // Start of frame always lands in slot 0; a partial frame in
                // progress is abandoned and flagged.
                fill_buf_r[0] <= bus.in_data;
                wr_idx_r      <= IDX_W'(1);
                if (wr_idx_r != '0) begin
                    sync_err_r <= 1'b1;
                end
            end else begin
                fill_buf_r[wr_idx_r] <= bus.in_data;
                if (wr_idx_r == LAST_IDX) begin
                    wr_idx_r    <= '0;
                    fill_full_r <= 1'b1;
                end else begin
                    wr_idx_r <= wr_idx_r + IDX_W'(1);
                end
            end
        end else if (transfer_s) begin
            fill_full_r <= 1'b0;
        end
    end

    // Output side: frame register, valid/start flags and release counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_data_r  <= '0;
            frame_valid_r <= 1'b0;
            frame_start_r <= 1'b0;
            frames_out_r  <= '0;
        end else begin
            if (transfer_s) begin
                frame_data_r  <= fill_flat_s;
                frame_valid_r <= 1'b1;
                frame_start_r <= 1'b1;
            end else begin
                frame_start_r <= 1'b0;
                if (release_s) begin
                    frame_valid_r <= 1'b0;
                end
            end
            if (release_s) begin
                frames_out_r <= frames_out_r + CNT_W'(1);
            end
        end
    end

    frame_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk           (clk),
        .rst           (rst),
        .frame_valid   (frame_valid_r),
        .load          (transfer_s),
        .frame_ready   (bus.frame_ready),
        .frame_release (release_s)
    );

    assign bus.in_ready    = !fill_full_r;
    assign bus.frame_data  = frame_data_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.sync_err    = sync_err_r;
    assign bus.frames_out  = frames_out_r;

endmodule

// File: tb/tb_adder_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_adder_frame_loader
// Directed vectors with hand-computed expectations for adder_frame_loader,
// followed by a randomised stream checked against an input-order scoreboard.
// frames_out is built 4 bits wide here so that its wrap is exercised.
// ---------------------------------------------------------------------------
module tb_adder_frame_loader;

    localparam int N     = 30;
    localparam int W     = 8;
    localparam int H     = 5;
    localparam int CW    = 4;
    localparam int FW    = N * W;
    localparam int NRAND = 150;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    adder_frame_loader_if #(.NUM_INPUTS(N), .DATA_W(W), .CNT_W(CW)) ifc ();

    adder_frame_loader #(
        .NUM_INPUTS  (N),
        .DATA_W      (W),
        .HOLD_CYCLES (H),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [FW-1:0] exp_q [$];
    int            got_cnt  = 0;
    bit            mon_en   = 1'b0;
    bit            drv_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fsum(input logic [FW-1:0] fd);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(fd[k*W +: W]);
        return s;
    endfunction

    function automatic int opk(input logic [FW-1:0] fd, input int k);
        return int'(fd[k*W +: W]);
    endfunction

    // Offer one byte starting at a negedge; returns at the negedge after it
    // was accepted.
    task automatic send_byte(input logic [7:0] d, input logic sof);
        int n = 0;
        ifc.in_data  = d;
        ifc.in_sof   = sof;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", 64'(n), 64'd0);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.in_sof   = 1'b0;
    endtask

    // Called at the negedge after the last byte; captures the frame in its
    // first valid cycle and measures how many cycles it stays valid.
    task automatic take_frame(input string tag, output logic [FW-1:0] fd, output int len);
        @(negedge clk);
        chk({tag, "_start"}, 64'({ifc.frame_valid, ifc.frame_start}), 64'd3);
        chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd1);
        fd  = ifc.frame_data;
        len = 1;
        @(negedge clk);
        while (ifc.frame_valid && len < 50) begin
            len++;
            @(negedge clk);
        end
    endtask

    // Scoreboard monitor for the random phase: each new frame must match the
    // oldest frame the driver sent.
    always @(negedge clk) begin
        if (mon_en && ifc.frame_valid && ifc.frame_start) begin
            if (exp_q.size() == 0) begin
                chk("t6_unexpected_frame", 64'd1, 64'd0);
            end else begin
                chk("t6_frame_match", 64'(ifc.frame_data == exp_q.pop_front()), 64'd1);
                got_cnt++;
            end
        end
    end

    initial begin
        logic [FW-1:0] fd;
        logic [FW-1:0] fr;
        int            len;
        int            n;
        int            base;

        ifc.in_data     = 8'd0;
        ifc.in_valid    = 1'b0;
        ifc.in_sof      = 1'b0;
        ifc.frame_ready = 1'b0;

        // ---- Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_frame_valid", 64'(ifc.frame_valid), 64'd0);
        chk("rst_frame_start", 64'(ifc.frame_start), 64'd0);
        chk("rst_in_ready",    64'(ifc.in_ready),    64'd1);
        chk("rst_frames_out",  64'(ifc.frames_out),  64'd0);
        chk("rst_sync_err",    64'(ifc.sync_err),    64'd0);
        chk("rst_frame_data",  64'(fsum(ifc.frame_data)), 64'd0);

        // ---- Test 1: bytes 1..30, consumer always ready
        ifc.frame_ready = 1'b1;
        for (int k = 0; k < N; k++) send_byte(8'(k + 1), (k == 0));
        chk("t1_gap_valid",    64'(ifc.frame_valid), 64'd0);
        chk("t1_gap_in_ready", 64'(ifc.in_ready),    64'd0);
        take_frame("t1", fd, len);
        chk("t1_op0",   64'(opk(fd, 0)),  64'd1);
        chk("t1_op29",  64'(opk(fd, 29)), 64'd30);
        chk("t1_sum",   64'(fsum(fd)),    64'd465);
        chk("t1_len",   64'(len),         64'd5);
        chk("t1_count", 64'(ifc.frames_out), 64'd1);

        // ---- Test 2: backpressure, then back-to-back load
        ifc.frame_ready = 1'b0;
        for (int k = 0; k < 2*N; k++) send_byte(8'(k + 1), (k % N == 0));
        chk("t2_held_valid", 64'(ifc.frame_valid), 64'd1);
        chk("t2_held_op0",   64'(opk(ifc.frame_data, 0)), 64'd1);
        ifc.in_data  = 8'd61;
        ifc.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_byte61_blocked", 64'(ifc.in_ready), 64'd0);
        ifc.in_valid    = 1'b0;
        ifc.frame_ready = 1'b1;
        @(negedge clk);
        chk("t2_b2b_valid_start", 64'({ifc.frame_valid, ifc.frame_start}), 64'd3);
        chk("t2_b2b_op0",  64'(opk(ifc.frame_data, 0)), 64'd31);
        chk("t2_b2b_sum",  64'(fsum(ifc.frame_data)),   64'd1365);
        chk("t2_count_a",  64'(ifc.frames_out), 64'd2);
        n = 0;
        while (ifc.frame_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t2_drain_cycles", 64'(n), 64'd5);
        chk("t2_count_b", 64'(ifc.frames_out), 64'd3);

        // ---- Test 3a: early frame_ready pulses are ignored
        ifc.frame_ready = 1'b0;
        for (int k = 0; k < N; k++) send_byte(8'(3 * k), (k == 0));
        ifc.frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_start", 64'(ifc.frame_start), 64'd1);
            ifc.frame_ready = (i < 3);
        end
        repeat (3) @(negedge clk);
        chk("t3_still_valid", 64'(ifc.frame_valid), 64'd1);
        chk("t3_no_release",  64'(ifc.frames_out),  64'd3);
        chk("t3_sum",         64'(fsum(ifc.frame_data)), 64'd1305);
        ifc.frame_ready = 1'b1;
        @(negedge clk);
        chk("t3_released",     64'(ifc.frame_valid), 64'd0);
        chk("t3_count",        64'(ifc.frames_out),  64'd4);

        // ---- Test 3b: ready from the first valid cycle gives exactly H cycles
        for (int k = 0; k < N; k++) send_byte(8'd7, (k == 0));
        take_frame("t3b", fd, len);
        chk("t3b_sum",   64'(fsum(fd)), 64'd210);
        chk("t3b_len",   64'(len),      64'(H));
        chk("t3b_count", 64'(ifc.frames_out), 64'd5);

        // ---- Test 4: in_sof mid-frame resynchronises
        for (int k = 0; k < 12; k++) send_byte(8'(k + 1), (k == 0));
        chk("t4_no_err_yet", 64'(ifc.sync_err), 64'd0);
        send_byte(8'hAA, 1'b1);
        chk("t4_sync_err", 64'(ifc.sync_err), 64'd1);
        for (int k = 1; k < N; k++) send_byte(8'(50 + k), 1'b0);
        take_frame("t4", fd, len);
        chk("t4_op0",   64'(opk(fd, 0)), 64'd170);
        chk("t4_op1",   64'(opk(fd, 1)), 64'd51);
        chk("t4_sum",   64'(fsum(fd)),   64'd2055);
        chk("t4_len",   64'(len),        64'd5);
        chk("t4_count", 64'(ifc.frames_out), 64'd6);

        // ---- Test 5: reset mid-fill and while a frame is held
        for (int k = 0; k < 17; k++) send_byte(8'(200 + k), (k == 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5a_valid",    64'(ifc.frame_valid), 64'd0);
        chk("t5a_data",     64'(fsum(ifc.frame_data)), 64'd0);
        chk("t5a_count",    64'(ifc.frames_out), 64'd0);
        chk("t5a_in_ready", 64'(ifc.in_ready),   64'd1);
        chk("t5a_sync_err", 64'(ifc.sync_err),   64'd0);
        ifc.frame_ready = 1'b0;
        for (int k = 0; k < N; k++) send_byte(8'(k + 1), 1'b0);
        @(negedge clk);
        chk("t5b_held",     64'(ifc.frame_valid), 64'd1);
        chk("t5b_held_op0", 64'(opk(ifc.frame_data, 0)), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5b_valid",    64'(ifc.frame_valid), 64'd0);
        chk("t5b_data",     64'(fsum(ifc.frame_data)), 64'd0);
        chk("t5b_count",    64'(ifc.frames_out), 64'd0);
        chk("t5b_in_ready", 64'(ifc.in_ready),   64'd1);
        ifc.frame_ready = 1'b1;
        for (int k = 0; k < N; k++) send_byte(8'(k + 1), 1'b0);
        take_frame("t5c", fd, len);
        chk("t5c_sum",   64'(fsum(fd)), 64'd465);
        chk("t5c_len",   64'(len),      64'd5);
        chk("t5c_count", 64'(ifc.frames_out), 64'd1);

        // ---- Test 6: random gaps and consumer readiness, scoreboarded
        base   = int'(ifc.frames_out);
        mon_en = 1'b1;
        fork
            begin
                for (int f = 0; f < NRAND; f++) begin
                    for (int k = 0; k < N; k++) fr[k*W +: W] = 8'($urandom);
                    exp_q.push_back(fr);
                    for (int k = 0; k < N; k++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        send_byte(fr[k*W +: W], (k == 0));
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(negedge clk);
                    ifc.frame_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ifc.frame_ready = 1'b1;
        n = 0;
        while ((got_cnt < NRAND || ifc.frame_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_frames_seen", 64'(got_cnt), 64'(NRAND));
        chk("t6_count_wrap",  64'(ifc.frames_out), 64'((base + NRAND) % (1 << CW)));
        chk("t6_sync_err",    64'(ifc.sync_err), 64'd0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
